// File: rtl/serial_axil_regs.sv
// rtl/serial_axil_regs.sv - AXI4-Lite responder register bank for the serial core
// Independent AW/W holding buffers feed a single commit point; reads use a two-state IDLE/RESP FSM.
module serial_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]                  reg_wr_pulse,
    output logic [NUM_REGS-1:0]                  reg_rd_pulse
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IW:0] NR_W = (IW+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    logic              r_up;
    logic              r_aw_full;
    logic [IW-1:0]     r_aw_idx;
    logic              r_w_full;
    logic [DW-1:0]     r_w_data;
    logic [SW-1:0]     r_w_strb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [DW-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic [NUM_REGS-1:0] r_rd_pulse;
    rd_state_t         r_rd_state;
    rd_state_t         w_rd_state_nxt;
    logic [DW-1:0]     r_rdata;
    logic [1:0]        r_rresp;

    logic              w_awready;
    logic              w_wready;
    logic              w_arready;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [IW-1:0]     w_c_idx;
    logic [DW-1:0]     w_c_data;
    logic [SW-1:0]     w_c_strb;
    logic              w_c_map;
    logic [IW-1:0]     w_ar_idx;
    logic              w_ar_map;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic [NUM_REGS-1:0] w_rd_sel;
    logic [DW-1:0]     w_rd_data;
    logic              w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // r_up keeps every READY low while reset is held and for the first cycle after it.
    assign w_awready = r_up & ~r_aw_full & ~r_bvalid;
    assign w_wready  = r_up & ~r_w_full & ~r_bvalid;
    assign w_arready = r_up & (r_rd_state == RD_IDLE);
    assign w_aw_hs   = S_AXI_AWVALID & w_awready;
    assign w_w_hs    = S_AXI_WVALID & w_wready;
    assign w_ar_hs   = S_AXI_ARVALID & w_arready;

    assign w_commit = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
    assign w_c_idx  = r_aw_full ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_c_data = r_w_full ? r_w_data : S_AXI_WDATA;
    assign w_c_strb = r_w_full ? r_w_strb : S_AXI_WSTRB;
    assign w_c_map  = ({1'b0, w_c_idx} < NR_W);
    assign w_ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_ar_map = ({1'b0, w_ar_idx} < NR_W);

    always_comb begin
        w_wr_sel  = '0;
        w_rd_sel  = '0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_sel[i] = w_commit & (w_c_idx == IW'(i));
            w_rd_sel[i] = w_ar_hs & (w_ar_idx == IW'(i));
            if (w_ar_idx == IW'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_up       <= 1'b0;
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_up       <= 1'b1;
            r_wr_pulse <= w_wr_sel;
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_c_map ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
                if (r_bvalid && S_AXI_BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < SW; b++) begin
                    if (w_wr_sel[i] && w_c_strb[b]) begin
                        r_regs[i][8*b +: 8] <= w_c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs) w_rd_state_nxt = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) w_rd_state_nxt = RD_IDLE;
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Sampling r_regs here on the same edge as a commit returns the pre-write value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= w_rd_sel;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_ar_map ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[DW*g +: DW] = r_regs[g];
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = (r_rd_state == RD_RESP);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign reg_wr_pulse  = r_wr_pulse;
    assign reg_rd_pulse  = r_rd_pulse;

endmodule

// File: tb/tb_serial_axil_regs.sv
// tb/tb_serial_axil_regs.sv - scoreboard bench for serial_axil_regs
// Three mapped registers in a four-slot address space, so index 3 exercises the unmapped path.
module tb_serial_axil_regs;

    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [32*NR-1:0] reg_q;
    logic [NR-1:0] wr_pulse, rd_pulse;

    serial_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .reg_q(reg_q),
        .reg_wr_pulse(wr_pulse),
        .reg_rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
    } b_exp_t;

    typedef struct {
        logic [31:0]   data;
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
    } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    logic [31:0] m_regs [NR];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_q();
        logic [127:0] q = '0;
        for (int i = 0; i < NR; i++) q[32*i +: 32] = m_regs[i];
        return q;
    endfunction

    // Model: a write to a mapped index merges enabled bytes; unmapped is an error with no effect.
    task automatic push_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        b_exp_t e;
        int idx = int'(addr[3:2]);
        e.pulse = '0;
        if (idx < NR) begin
            e.resp = 2'b00;
            e.pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            e.resp = 2'b10;
        end
        bq.push_back(e);
    endtask

    task automatic push_read(input logic [3:0] addr, output logic [31:0] exp_data);
        r_exp_t e;
        int idx = int'(addr[3:2]);
        e.pulse = '0;
        e.data = 32'h0;
        e.resp = 2'b10;
        if (idx < NR) begin
            e.data = m_regs[idx];
            e.resp = 2'b00;
            e.pulse[idx] = 1'b1;
        end
        exp_data = e.data;
        rq.push_back(e);
    endtask

    task automatic hs_aw(input logic [3:0] addr);
        int n = 0;
        awaddr = addr; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) chk("aw_timeout", 1, 0);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic hs_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) chk("w_timeout", 1, 0);
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic hs_both(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        @(negedge clk);
        while (!(awready && wready) && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) chk("aww_timeout", 1, 0);
        @(posedge clk); #1 begin awvalid = 1'b0; wvalid = 1'b0; end
    endtask

    // mode 0: AW+W together, 1: AW first, 2: W first; gap cycles between; bdelay cycles of BREADY low.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int mode, input int gap, input int bdelay);
        push_write(addr, data, strb);
        if (mode == 0) begin
            hs_both(addr, data, strb);
        end else begin
            if (mode == 1) hs_aw(addr); else hs_w(data, strb);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); chk("bvalid_early", bvalid, 0);
                @(posedge clk); #1;
            end
            if (mode == 1) hs_w(data, strb); else hs_aw(addr);
        end
        @(negedge clk); chk("b_latency", bvalid, 1);
        for (int d = 0; d < bdelay; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_rdy", {awready, wready}, 0);
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        chk("reg_q", reg_q, model_q());
    endtask

    task automatic do_read(input logic [3:0] addr, input int rdelay);
        int n = 0;
        logic [31:0] ed;
        push_read(addr, ed);
        araddr = addr; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) chk("ar_timeout", 1, 0);
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk); chk("r_latency", rvalid, 1);
        for (int d = 0; d < rdelay; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_arrdy", arready, 0);
            chk("r_hold_data", rdata, ed);
        end
        @(posedge clk); #1 rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    // Monitor: pops one expectation each time a VALID rises; pulses must be idle otherwise.
    b_exp_t cur_b;
    r_exp_t cur_r;
    logic   prev_b = 1'b0, prev_r = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_b = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (bvalid && !prev_b) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                end else begin
                    cur_b = bq.pop_front();
                    chk("bresp", bresp, cur_b.resp);
                    chk("wr_pulse", wr_pulse, cur_b.pulse);
                end
            end else begin
                chk("wr_pulse_idle", wr_pulse, 0);
            end
            if (bvalid && bready) chk("bresp_at_hs", bresp, cur_b.resp);
            if (rvalid && !prev_r) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    cur_r = rq.pop_front();
                    chk("rdata", rdata, cur_r.data);
                    chk("rresp", rresp, cur_r.resp);
                    chk("rd_pulse", rd_pulse, cur_r.pulse);
                end
            end else begin
                chk("rd_pulse_idle", rd_pulse, 0);
            end
            if (rvalid && rready) begin
                chk("rdata_at_hs", rdata, cur_r.data);
                chk("rresp_at_hs", rresp, cur_r.resp);
            end
            prev_b = bvalid;
            prev_r = rvalid;
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_rdy"}, {awready, wready, arready}, 0);
        chk({tag, "_valid"}, {bvalid, rvalid}, 0);
        chk({tag, "_resp"}, {bresp, rresp}, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_pulse"}, {wr_pulse, rd_pulse}, 0);
        chk({tag, "_regq"}, reg_q, 0);
    endtask

    initial begin
        logic [31:0] ed;
        int n;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        #3 reset_checks("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 4; i++)
            do_write(4'(4*i), 32'(i+1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            do_read(4'(4*i), 0);

        do_write(4'h4, 32'hA5A5A5A5, 4'hF, 2, 3, 0);
        do_read(4'h4, 0);

        do_write(4'h0, 32'h11223344, 4'hF, 1, 2, 0);
        do_write(4'h0, 32'hFFFFFFFF, 4'b0101, 0, 0, 0);
        do_read(4'h0, 0);
        do_write(4'h8, 32'hDEADBEEF, 4'h0, 0, 0, 0);

        do_write(4'h8, 32'hCAFEF00D, 4'hF, 0, 0, 5);
        do_read(4'h8, 5);
        do_write(4'hC, 32'h12345678, 4'hF, 0, 0, 5);
        do_read(4'hF, 5);

        // Commit and AR on the same edge: read must return the value before the write.
        push_read(4'h1, ed);
        hs_aw(4'h0);
        push_write(4'h0, 32'h0BADF00D, 4'hF);
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 4'h1; arvalid = 1'b1;
        @(negedge clk); chk("overlap_rdy", {wready, arready}, 2'b11);
        @(posedge clk); #1 begin wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1; end
        @(posedge clk); #1 begin bready = 1'b0; rready = 1'b0; end
        do_read(4'h0, 0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        // Reset while BVALID is high and a further W is pending.
        push_write(4'h4, 32'h55AA55AA, 4'hF);
        hs_both(4'h4, 32'h55AA55AA, 4'hF);
        @(negedge clk); chk("pre_rst_bvalid", bvalid, 1);
        @(posedge clk); #1 begin wdata = 32'h77777777; wvalid = 1'b1; end
        #2 rst = 1'b1;
        #1 reset_checks("async_rst");
        wvalid = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        @(posedge clk); #1 rst = 1'b0;
        do_write(4'h4, 32'h01020304, 4'hF, 0, 0, 0);
        do_read(4'h4, 0);

        // A W buffered before reset must not pair with an AW after reset.
        hs_w(32'hDEADDEAD, 4'hF);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        push_write(4'h8, 32'h87654321, 4'hF);
        hs_aw(4'h8);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk); chk("stale_w_bvalid", bvalid, 0);
            @(posedge clk); #1;
        end
        hs_w(32'h87654321, 4'hF);
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        do_read(4'h8, 0);
        chk("final_reg_q", reg_q, model_q());

        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin n++; @(posedge clk); end
        chk("queues_drained", bq.size() + rq.size(), 0);
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
